// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: register select, FSM
// state and the bundle of latch enables/flushes it drives.
package hazard_ctrl_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DWAIT     = 2'd1,
    FLUSHPEND = 2'd2,
    HALT      = 2'd3
  } hazard_state_t;

  // Bit order matches the latch order down the pipe, enables then flushes.
  typedef struct packed {
    logic pcEn;
    logic ifidEn;
    logic idexEn;
    logic exmemEn;
    logic memwbEn;
    logic ifidFlush;
    logic idexFlush;
    logic exmemFlush;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_GO  = 8'b11111_000;
  localparam hz_ctrl_t CTRL_OFF = 8'b00000_000;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: every controller signal except clock and reset.
// hz is the controller side, tb the pipeline/bench side.
interface hazard_if #(parameter int REGW = 5);
  logic            ihit;
  logic            dhit;
  logic            mem_dREN;
  logic            mem_dWEN;
  logic            ex_dREN;
  logic [REGW-1:0] ex_writeReg;
  logic [REGW-1:0] id_rs;
  logic [REGW-1:0] id_rt;
  logic            id_uses_rt;
  logic            mem_branch_taken;
  logic            id_jump;
  logic            wb_halt;
  logic            pc_en;
  logic            ifid_en;
  logic            idex_en;
  logic            exmem_en;
  logic            memwb_en;
  logic            ifid_flush;
  logic            idex_flush;
  logic            exmem_flush;
  logic            halted;
  logic [1:0]      hz_state;
  logic [31:0]     stall_cycles;
  logic [31:0]     flush_count;

  modport hz (
    input  ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_writeReg, id_rs, id_rt,
           id_uses_rt, mem_branch_taken, id_jump, wb_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halted, hz_state,
           stall_cycles, flush_count
  );

  modport tb (
    output ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_writeReg, id_rs, id_rt,
           id_uses_rt, mem_branch_taken, id_jump, wb_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halted, hz_state,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_ctrl_load_use_detect.sv
// Load-use compare: the load in EX writes a register the ID instruction
// reads. $0 is never a real dependency.
module load_use_detect #(parameter int REGW = 5) (
  input  logic            exDRen,
  input  logic [REGW-1:0] exWriteReg,
  input  logic [REGW-1:0] idRs,
  input  logic [REGW-1:0] idRt,
  input  logic            idUsesRt,
  output logic            luse
);
  assign luse = exDRen && (exWriteReg != '0) &&
                ((exWriteReg == idRs) || (idUsesRt && (exWriteReg == idRt)));
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS datapath. Drives all
// latch enables and bubble flushes; outputs are combinational from state and
// inputs. Optional perf counters are built when HAZARD_PERF_EN is defined,
// otherwise stall_cycles/flush_count read as zero.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REGW = 5  // must match $bits(regbits_t)
) (
  input logic CLK,
  input logic RST,
  hazard_if.hz bus
);

  hazard_state_t state, nextState;
  hz_ctrl_t      ctrl;
  logic          luse, dStall, fireBr, fireJmp;

  load_use_detect #(.REGW(REGW)) uLuse (
    .exDRen    (bus.ex_dREN),
    .exWriteReg(bus.ex_writeReg),
    .idRs      (bus.id_rs),
    .idRt      (bus.id_rt),
    .idUsesRt  (bus.id_uses_rt),
    .luse      (luse)
  );

  assign dStall = (bus.mem_dREN | bus.mem_dWEN) & ~bus.dhit;

  // Priority resolution of stalls/flushes and next-state selection.
  always_comb begin
    ctrl      = CTRL_GO;
    nextState = state;
    fireBr    = 1'b0;
    fireJmp   = 1'b0;
    case (state)
      HALT: ctrl = CTRL_OFF;
      FLUSHPEND: begin
        if (bus.wb_halt) begin
          ctrl      = CTRL_OFF;
          nextState = HALT;
        end else if (dStall) begin
          ctrl = CTRL_OFF;  // hold the pending discard until memory frees
        end else if (bus.mem_branch_taken) begin
          ctrl.ifidFlush  = 1'b1;
          ctrl.idexFlush  = 1'b1;
          ctrl.exmemFlush = 1'b1;
          fireBr          = 1'b1;
          nextState       = bus.ihit ? RUN : FLUSHPEND;
        end else begin
          // Wrong-path fetch still in flight: keep PC on the target and
          // throw away whatever lands in IF/ID, including the returning word.
          ctrl.pcEn      = 1'b0;
          ctrl.ifidFlush = 1'b1;
          nextState      = bus.ihit ? RUN : FLUSHPEND;
        end
      end
      default: begin  // RUN, and DWAIT once the data access completes
        if (state == DWAIT && !bus.dhit) begin
          ctrl = CTRL_OFF;
        end else if (bus.wb_halt) begin
          ctrl      = CTRL_OFF;
          nextState = HALT;
        end else if (dStall) begin
          ctrl      = CTRL_OFF;
          nextState = DWAIT;
        end else if (bus.mem_branch_taken) begin
          ctrl.ifidFlush  = 1'b1;
          ctrl.idexFlush  = 1'b1;
          ctrl.exmemFlush = 1'b1;
          fireBr          = 1'b1;
          nextState       = bus.ihit ? RUN : FLUSHPEND;
        end else if (luse) begin
          ctrl.pcEn      = 1'b0;
          ctrl.ifidEn    = 1'b0;
          ctrl.idexFlush = 1'b1;
          nextState      = RUN;
        end else if (bus.id_jump) begin
          ctrl.ifidFlush = 1'b1;
          fireJmp        = 1'b1;
          nextState      = bus.ihit ? RUN : FLUSHPEND;
        end else if (!bus.ihit) begin
          ctrl.pcEn      = 1'b0;
          ctrl.ifidFlush = 1'b1;
          nextState      = RUN;
        end else begin
          nextState = RUN;
        end
      end
    endcase
    if (RST) ctrl = CTRL_OFF;
  end

  // State register; reset forgets any pending wrong-path fetch.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= RUN;
    else     state <= nextState;
  end

  assign bus.pc_en       = ctrl.pcEn;
  assign bus.ifid_en     = ctrl.ifidEn;
  assign bus.idex_en     = ctrl.idexEn;
  assign bus.exmem_en    = ctrl.exmemEn;
  assign bus.memwb_en    = ctrl.memwbEn;
  assign bus.ifid_flush  = ctrl.ifidFlush;
  assign bus.idex_flush  = ctrl.idexFlush;
  assign bus.exmem_flush = ctrl.exmemFlush;
  assign bus.halted      = (state == HALT) & ~RST;
  assign bus.hz_state    = state;

`ifdef HAZARD_PERF_EN
  logic [31:0] stallCnt, flushCnt;

  // Saturating stall/flush counters, frozen once halted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else if (state != HALT) begin
      if (!ctrl.pcEn && stallCnt != '1)           stallCnt <= stallCnt + 32'd1;
      if ((fireBr || fireJmp) && flushCnt != '1)  flushCnt <= flushCnt + 32'd1;
    end
  end

  assign bus.stall_cycles = stallCnt;
  assign bus.flush_count  = flushCnt;
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a rule-table model scored every cycle plus
// hand-computed literal expectations at each scenario's key cycles.
module tb_hazard_ctrl;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  hazard_if #(.REGW(5)) bus();
  hazard_ctrl #(.REGW(5)) dut (.CLK(CLK), .RST(RST), .bus(bus.hz));

  int checks = 0;
  int passes = 0;

  logic [7:0] dutVec;
  assign dutVec = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                   bus.ifid_flush, bus.idex_flush, bus.exmem_flush};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Expected {pc,ifid,idex,exmem,memwb enables, ifid,idex,exmem flushes} per rule:
  // 1 halt, 2 data wait, 3 branch, 4 load-use, 5 jump, 6 imiss,
  // 7 normal, 8 halted, 9 discard pending fetch.
  logic [7:0] ruleOut [0:9];
  initial begin
    ruleOut[0] = 8'b00000_000;
    ruleOut[1] = 8'b00000_000;
    ruleOut[2] = 8'b00000_000;
    ruleOut[3] = 8'b11111_111;
    ruleOut[4] = 8'b00111_010;
    ruleOut[5] = 8'b11111_100;
    ruleOut[6] = 8'b01111_100;
    ruleOut[7] = 8'b11111_000;
    ruleOut[8] = 8'b00000_000;
    ruleOut[9] = 8'b01111_100;
  end

  // Model state as plain flags rather than an encoded state.
  bit mHalt, mDwait, mFpend;
  int unsigned mStall, mFlush;

  function automatic logic [31:0] perfExp(input int unsigned v);
`ifdef HAZARD_PERF_EN
    return 32'(v);
`else
    return 32'(v) & 32'd0;
`endif
  endfunction

  initial begin : scoreboard
    int r;
    bit dmiss, lu, nHalt, nDw, nFp;
    int unsigned nStall, nFlush;
    logic [1:0] expSt;
    forever begin
      @(negedge CLK);
      if (RST) begin
        check("rst_vec", 32'(dutVec), 32'd0);
        check("rst_state", 32'(bus.hz_state), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        check("rst_stall", bus.stall_cycles, 32'd0);
        check("rst_flush", bus.flush_count, 32'd0);
        nHalt = 0; nDw = 0; nFp = 0; nStall = 0; nFlush = 0;
      end else begin
        dmiss = (bus.mem_dREN | bus.mem_dWEN) & ~bus.dhit;
        lu = bus.ex_dREN && bus.ex_writeReg != 0 &&
             (bus.ex_writeReg == bus.id_rs || (bus.id_uses_rt && bus.ex_writeReg == bus.id_rt));
        if (mHalt)                      r = 8;
        else if (mDwait && !bus.dhit)   r = 2;
        else if (bus.wb_halt)           r = 1;
        else if (dmiss)                 r = 2;
        else if (mFpend)                r = bus.mem_branch_taken ? 3 : 9;
        else if (bus.mem_branch_taken)  r = 3;
        else if (lu)                    r = 4;
        else if (bus.id_jump)           r = 5;
        else if (!bus.ihit)             r = 6;
        else                            r = 7;
        expSt = mHalt ? 2'd3 : mDwait ? 2'd1 : mFpend ? 2'd2 : 2'd0;
        check("model_vec", 32'(dutVec), 32'(ruleOut[r]));
        check("model_state", 32'(bus.hz_state), 32'(expSt));
        check("model_halted", 32'(bus.halted), 32'(mHalt));
        check("model_stall", bus.stall_cycles, perfExp(mStall));
        check("model_flush", bus.flush_count, perfExp(mFlush));
        nHalt = mHalt; nDw = 0; nFp = 0;
        case (r)
          1:       nHalt = 1;
          2:       begin nFp = mFpend; nDw = !mFpend; end
          3, 5, 9: nFp = !bus.ihit;
          default: ;
        endcase
        nStall = mStall + ((!mHalt && !ruleOut[r][7]) ? 1 : 0);
        nFlush = mFlush + ((r == 3 || r == 5) ? 1 : 0);
      end
      @(posedge CLK or posedge RST);
      if (RST) begin
        mHalt = 0; mDwait = 0; mFpend = 0; mStall = 0; mFlush = 0;
      end else begin
        mHalt = nHalt; mDwait = nDw; mFpend = nFp; mStall = nStall; mFlush = nFlush;
      end
    end
  end

  task automatic idle();
    bus.ihit = 1; bus.dhit = 0; bus.mem_dREN = 0; bus.mem_dWEN = 0;
    bus.ex_dREN = 0; bus.ex_writeReg = 0; bus.id_rs = 0; bus.id_rt = 0;
    bus.id_uses_rt = 0; bus.mem_branch_taken = 0; bus.id_jump = 0; bus.wb_halt = 0;
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  initial begin : stim
    RST = 1; idle();
    #3;
    check("reset_vec", 32'(dutVec), 32'd0);
    check("reset_state", 32'(bus.hz_state), 32'd0);
    check("reset_halted", 32'(bus.halted), 32'd0);
    step(); step();
    RST = 0;

    // load-use on rs: one bubble, then free flow as the load reaches MEM
    bus.ex_dREN = 1; bus.ex_writeReg = 3; bus.id_rs = 3; #1;
    check("luse_rs_vec", 32'(dutVec), 32'h3A);
    step(); idle(); bus.mem_dREN = 1; bus.dhit = 1; #1;
    check("luse_clear_vec", 32'(dutVec), 32'hF8);
    step(); idle(); bus.ex_dREN = 1; #1;
    check("luse_r0_vec", 32'(dutVec), 32'hF8);
    step(); idle();
    bus.ex_dREN = 1; bus.ex_writeReg = 5; bus.id_rs = 2; bus.id_rt = 5; bus.id_uses_rt = 1; #1;
    check("luse_rt_vec", 32'(dutVec), 32'h3A);
    step(); bus.id_uses_rt = 0; #1;
    check("luse_rt_unused_vec", 32'(dutVec), 32'hF8);
    step(); idle();

    // data wait: three frozen cycles, release on dhit
    bus.mem_dREN = 1; #1;
    check("dmiss_vec", 32'(dutVec), 32'd0);
    check("dmiss_state", 32'(bus.hz_state), 32'd0);
    step(); #1;
    check("dwait1_state", 32'(bus.hz_state), 32'd1);
    check("dwait1_vec", 32'(dutVec), 32'd0);
    step(); #1;
    check("dwait2_vec", 32'(dutVec), 32'd0);
    step(); bus.dhit = 1; #1;
    check("dwait_rel_state", 32'(bus.hz_state), 32'd1);
    check("dwait_rel_vec", 32'(dutVec), 32'hF8);
    step(); idle(); #1;
    check("dwait_exit_state", 32'(bus.hz_state), 32'd0);

    // taken branch with fetch outstanding
    bus.mem_branch_taken = 1; bus.ihit = 0; #1;
    check("br_vec", 32'(dutVec), 32'hFF);
    step(); bus.mem_branch_taken = 0; #1;
    check("fpend1_state", 32'(bus.hz_state), 32'd2);
    check("fpend1_vec", 32'(dutVec), 32'h7C);
    step(); #1;
    check("fpend2_vec", 32'(dutVec), 32'h7C);
    step(); bus.ihit = 1; #1;
    check("fpend_hit_state", 32'(bus.hz_state), 32'd2);
    check("fpend_hit_vec", 32'(dutVec), 32'h7C);
    step(); #1;
    check("fpend_exit_state", 32'(bus.hz_state), 32'd0);
    check("fpend_exit_vec", 32'(dutVec), 32'hF8);

    // branch beats load-use
    bus.mem_branch_taken = 1; bus.ex_dREN = 1; bus.ex_writeReg = 4; bus.id_rs = 4; #1;
    check("br_over_luse_vec", 32'(dutVec), 32'hFF);
    step(); idle();

    // jumps, with and without the fetch done; data miss while pending
    bus.id_jump = 1; #1;
    check("jump_vec", 32'(dutVec), 32'hFC);
    step(); idle(); #1;
    check("jump_exit_state", 32'(bus.hz_state), 32'd0);
    bus.id_jump = 1; bus.ihit = 0; #1;
    check("jump_miss_vec", 32'(dutVec), 32'hFC);
    step(); idle(); bus.ihit = 0; bus.mem_dWEN = 1; #1;
    check("fpend_dmiss_vec", 32'(dutVec), 32'd0);
    check("fpend_dmiss_state", 32'(bus.hz_state), 32'd2);
    step(); bus.dhit = 1; bus.ihit = 1; #1;
    check("fpend_dhit_vec", 32'(dutVec), 32'h7C);
    step(); idle(); #1;
    check("fpend_dhit_exit", 32'(bus.hz_state), 32'd0);

    // plain instruction miss
    bus.ihit = 0; #1;
    check("imiss_vec", 32'(dutVec), 32'h7C);
    step(); idle();

    // reset in the middle of a data wait
    bus.mem_dREN = 1; step(); #1;
    check("pre_rst_state", 32'(bus.hz_state), 32'd1);
    RST = 1; #1;
    check("mid_rst_state", 32'(bus.hz_state), 32'd0);
    check("mid_rst_vec", 32'(dutVec), 32'd0);
    step(); RST = 0; idle();

    // counter scenario: load-use + 3 data-wait stalls + one branch
    bus.ex_dREN = 1; bus.ex_writeReg = 3; bus.id_rs = 3;
    step(); idle();
    bus.mem_dREN = 1; step(); step(); step();
    bus.dhit = 1; step(); idle();
    bus.mem_branch_taken = 1; step(); idle(); #1;
`ifdef HAZARD_PERF_EN
    check("perf_stall", bus.stall_cycles, 32'd4);
    check("perf_flush", bus.flush_count, 32'd1);
`else
    check("perf_stall_tied", bus.stall_cycles, 32'd0);
    check("perf_flush_tied", bus.flush_count, 32'd0);
`endif

    // halt is sticky until reset
    bus.wb_halt = 1; #1;
    check("halt_fire_vec", 32'(dutVec), 32'd0);
    step(); idle(); bus.mem_branch_taken = 1; bus.ihit = 0; #1;
    check("halted_flag", 32'(bus.halted), 32'd1);
    check("halted_state", 32'(bus.hz_state), 32'd3);
    check("halted_vec", 32'(dutVec), 32'd0);
    step(); step(); #1;
    check("halted_sticky", 32'(bus.halted), 32'd1);
    RST = 1; #1;
    check("halt_rst_flag", 32'(bus.halted), 32'd0);
    check("halt_rst_state", 32'(bus.hz_state), 32'd0);
    step(); RST = 0; idle(); step(); #1;
    check("post_halt_vec", 32'(dutVec), 32'hF8);
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS datapath. Sits beside the forwarding unit.
- Owns every latch enable and flush: PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves load-use stalls, instruction/data memory wait stalls, taken-branch/jump flushes and halt.
- Tracks a wrong-path fetch that is still outstanding across cycles.

Parameters:
- REGW, 5, register-select width; must equal the width of regbits_t.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-high reset
- ihit  in  1  instruction fetch completes this cycle
- dhit  in  1  data access completes this cycle
- mem_dREN, mem_dWEN  in  1 each  MEM-stage data read/write request
- ex_dREN  in  1  EX-stage instruction is a load
- ex_writeReg  in  REGW  EX-stage destination register
- id_rs, id_rt  in  REGW  ID-stage source registers
- id_uses_rt  in  1  ID instruction reads rt
- mem_branch_taken  in  1  branch/jr resolved taken in MEM; PC loads target when pc_en=1
- id_jump  in  1  j/jal decoded in ID
- wb_halt  in  1  halt instruction in WB
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables
- ifid_flush, idex_flush, exmem_flush  out  1 each  synchronous bubble insert
- halted  out  1  sticky halt flag
- hz_state  out  2  current FSM state, for debug

Behaviour:
- Definitions:
  - dreq = mem_dREN | mem_dWEN
  - luse = ex_dREN & (ex_writeReg != 0) & (ex_writeReg == id_rs | (id_uses_rt & ex_writeReg == id_rt))
- Outputs are combinational from state and inputs. Default: all enables 1, all flushes 0.
- A flush has priority over its own latch enable.
- FSM states: RUN=0, DWAIT=1, FLUSHPEND=2, HALT=3. Next-state register resets asynchronously to RUN.
- During RST all enables = 0, all flushes = 0, halted = 0, hz_state = RUN.
- RUN, priority highest first:
  1. wb_halt: all enables 0; next HALT.
  2. dreq & !dhit: all enables 0; next DWAIT.
  3. mem_branch_taken: pc_en=1; ifid_flush=idex_flush=exmem_flush=1; memwb_en=1. Next FLUSHPEND if !ihit, else RUN.
  4. luse: pc_en=0, ifid_en=0, idex_flush=1; EX/MEM and MEM/WB advance. Exactly one bubble; the hazard clears as the load moves to MEM.
  5. id_jump: pc_en=1, ifid_flush=1. Next FLUSHPEND if !ihit, else RUN.
  6. !ihit: pc_en=0, ifid_flush=1; downstream advances.
  7. Otherwise: all enables 1.
- DWAIT:
  - While !dhit: all enables 0, no flush.
  - On dhit: evaluate RUN rules with dhit treated as 1 in the same cycle; next state per those rules.
  - wb_halt cannot assert in DWAIT because MEM/WB is frozen.
- FLUSHPEND (wrong-path fetch outstanding):
  - pc_en=0, ifid_flush=1; ID/EX onward advance.
  - dreq & !dhit overrides: all enables 0, and FLUSHPEND is held.
  - ihit: the returned instruction is discarded (ifid_flush=1 this cycle); next RUN.
  - mem_branch_taken in FLUSHPEND: apply RUN rule 3 and stay in FLUSHPEND if !ihit.
  - wb_halt: rule 1 applies.
- HALT: all enables 0, all flushes 0, halted=1. Leaves only on RST.
- ex_writeReg = 0 never triggers luse.
- RST mid-stall drops to RUN asynchronously, with no pending-flush memory retained.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: adds 32-bit counters, reset to 0 by RST, saturating at 0xFFFFFFFF, frozen in HALT. Driven on outputs:
  - stall_cycles: increments each cycle pc_en=0 outside HALT.
  - flush_count: increments each cycle rule 3 or rule 5 fires.
- Not defined: the ports remain present and are tied to 0; no counter flops.

Decomposition:
- cpu_types_pkg: add hazard_state_t (2-bit enum RUN/DWAIT/FLUSHPEND/HALT); reuse regbits_t.
- New include/hazard_if.vh interface carrying all ports except CLK/RST, with modports hz and tb.
- One sub-module, load_use_detect: combinational luse compare.

Test Plan:
- lw $3 in EX with ex_writeReg=3, id_rs=3, ihit=1 → exactly one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle all enables 1.
- ex_writeReg=0, ex_dREN=1, id_rs=0 → no stall.
- mem_dREN=1, dhit=0 for 3 cycles then 1 → hz_state=DWAIT for 3 cycles with all enables 0; on the dhit cycle all enables 1, then RUN.
- mem_branch_taken=1 with ihit=0, then ihit=0 for 2 cycles, then ihit=1:
  - three flushes asserted in the branch cycle.
  - FLUSHPEND with ifid_flush=1 until the ihit cycle, then RUN.
- mem_branch_taken and luse asserted together → branch wins: idex_flush=1, pc_en=1.
- wb_halt=1 → halted=1 and enables 0 until RST. RST asserted mid-DWAIT → outputs reset immediately, hz_state=0.
- With HAZARD_PERF_EN defined: one load-use stall plus 3 DWAIT cycles plus 1 branch → stall_cycles=4, flush_count=1.
